// File: rtl/acc_pkg.sv
// Shared opcodes, flag bit positions and sizing helper for the accumulator bank.
package acc_pkg;
    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_LD  = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd3;
    localparam logic [2:0] OP_CLR = 3'd4;
    localparam logic [2:0] OP_INC = 3'd5;
    localparam logic [2:0] OP_DEC = 3'd6;
    localparam logic [2:0] OP_RSV = 3'd7;

    localparam int FLG_Z   = 0;
    localparam int FLG_C   = 1;
    localparam int FLG_O   = 2;
    localparam int FLG_S   = 3;
    localparam int NUM_FLG = 4;

    function automatic int sel_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/acc_bank_if.sv
// Op request / result bus between the datapath and the accumulator bank.
interface acc_bank_if #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 2
);
    logic             op_valid;
    logic [2:0]       op;
    logic [SEL_W-1:0] sel;
    logic [WIDTH-1:0] acc_in;
    logic [WIDTH-1:0] acc_out;
    logic             out_valid;
    logic             zero_f;
    logic             carry_f;
    logic             ovf_f;
    logic             sat_f;
    logic             op_err;

    modport master (
        output op_valid, op, sel, acc_in,
        input  acc_out, out_valid, zero_f, carry_f, ovf_f, sat_f, op_err
    );
    modport slave (
        input  op_valid, op, sel, acc_in,
        output acc_out, out_valid, zero_f, carry_f, ovf_f, sat_f, op_err
    );
endinterface

// File: rtl/acc_addsub.sv
// Combinational add/subtract with carry/borrow, signed overflow and optional clamping.
module acc_addsub #(
    parameter int WIDTH    = 8,
    parameter int SATURATE = 0,
    parameter int SIGNED   = 0
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             ovf,
    output logic             sat
);
    logic [WIDTH:0]   raw;
    logic [WIDTH-1:0] b_eff;

    always_comb begin
        b_eff  = sub ? (~b + 1'b1) : b;
        raw    = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
        // On subtract the extra bit wraps to 1 exactly when a < b, i.e. the borrow.
        carry  = raw[WIDTH];
        ovf    = (a[WIDTH-1] == b_eff[WIDTH-1]) && (raw[WIDTH-1] != a[WIDTH-1]);
        result = raw[WIDTH-1:0];
        sat    = 1'b0;
        if (SATURATE != 0) begin
            if (SIGNED != 0) begin
                if (ovf) begin
                    sat    = 1'b1;
                    result = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
                end
            end else if (carry) begin
                sat    = 1'b1;
                result = sub ? '0 : '1;
            end
        end
    end
endmodule

// File: rtl/acc_bank.sv
// Bank of NUM_ACC accumulators, one op per cycle, registered result and status flags.
module acc_bank
    import acc_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int NUM_ACC  = 4,
    parameter int SATURATE = 0,
    parameter int SIGNED   = 0,
    localparam int SEL_W   = sel_width(NUM_ACC)
) (
    input  logic      clk,
    input  logic      rst,
    acc_bank_if.slave bus
);
    logic [WIDTH-1:0]   bank [NUM_ACC];
    logic [SEL_W-1:0]   sel;
    logic               sel_ok, legal;
    logic [WIDTH-1:0]   cur, as_b, as_res, res;
    logic               as_sub, as_c, as_o, as_s;
    logic [NUM_FLG-1:0] flg_nxt, flags;
    logic [WIDTH-1:0]   acc_out;
    logic               out_valid, op_err;

    assign sel = bus.sel;

    acc_addsub #(.WIDTH(WIDTH), .SATURATE(SATURATE), .SIGNED(SIGNED)) u_addsub (
        .a(cur), .b(as_b), .sub(as_sub),
        .result(as_res), .carry(as_c), .ovf(as_o), .sat(as_s)
    );

    always_comb begin
        sel_ok  = int'(sel) < NUM_ACC;
        legal   = sel_ok && (bus.op != OP_RSV);
        cur     = sel_ok ? bank[sel] : '0;
        as_sub  = (bus.op == OP_SUB) || (bus.op == OP_DEC);
        as_b    = ((bus.op == OP_INC) || (bus.op == OP_DEC)) ? {{(WIDTH-1){1'b0}}, 1'b1} : bus.acc_in;
        res     = cur;
        flg_nxt = '0;
        case (bus.op)
            OP_LD:  res = bus.acc_in;
            OP_CLR: res = '0;
            OP_ADD, OP_SUB, OP_INC, OP_DEC: begin
                res            = as_res;
                flg_nxt[FLG_C] = as_c;
                flg_nxt[FLG_O] = as_o;
                flg_nxt[FLG_S] = as_s;
            end
            default: res = cur;
        endcase
        flg_nxt[FLG_Z] = (res == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_ACC; i++) bank[i] <= '0;
            acc_out   <= '0;
            flags     <= '0;
            out_valid <= 1'b0;
            op_err    <= 1'b0;
        end else begin
            out_valid <= bus.op_valid && legal;
            op_err    <= bus.op_valid && !legal;
            if (bus.op_valid && legal) begin
                acc_out <= res;
                flags   <= flg_nxt;
                // NOP is a read: report the register without writing it back.
                if (bus.op != OP_NOP) bank[sel] <= res;
            end
        end
    end

    assign bus.acc_out   = acc_out;
    assign bus.out_valid = out_valid;
    assign bus.op_err    = op_err;
    assign bus.zero_f    = flags[FLG_Z];
    assign bus.carry_f   = flags[FLG_C];
    assign bus.ovf_f     = flags[FLG_O];
    assign bus.sat_f     = flags[FLG_S];
endmodule

// File: tb/tb_acc_bank.sv
// Scoreboard bench: four acc_bank configurations share one stimulus bus, one active at a time.
module tb_acc_bank;
    import acc_pkg::*;

    localparam int ND = 4;  // 0: wrap, 1: unsigned sat, 2: signed sat, 3: wrap with NUM_ACC=3

    typedef struct packed {
        logic       err;
        logic [7:0] acc;
        logic [3:0] flg;  // {sat, ovf, carry, zero}
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       op_valid = 1'b0;
    logic [2:0] op = 3'd0;
    logic [1:0] sel = 2'd0;
    logic [7:0] acc_in = 8'd0;
    int         act = 0;

    logic [7:0] m_acc [ND];
    logic [3:0] m_flg [ND];
    logic       m_ov  [ND];
    logic       m_err [ND];

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : u
        acc_bank_if #(.WIDTH(8), .SEL_W(2)) bus ();
        assign bus.op_valid = op_valid && (act == g);
        assign bus.op       = op;
        assign bus.sel      = sel;
        assign bus.acc_in   = acc_in;
        acc_bank #(
            .WIDTH(8),
            .NUM_ACC((g == 3) ? 3 : 4),
            .SATURATE((g == 1 || g == 2) ? 1 : 0),
            .SIGNED((g == 2) ? 1 : 0)
        ) dut (
            .clk(clk),
            .rst(rst),
            .bus(bus.slave)
        );
        assign m_acc[g] = bus.acc_out;
        assign m_flg[g] = {bus.sat_f, bus.ovf_f, bus.carry_f, bus.zero_f};
        assign m_ov[g]  = bus.out_valid;
        assign m_err[g] = bus.op_err;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic monitor();
        exp_t got, e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int g = 0; g < ND; g++) begin
                    if (m_ov[g] || m_err[g]) begin
                        got = '{err: m_err[g], acc: m_acc[g], flg: m_flg[g]};
                        if (q.size() == 0) begin
                            chk($sformatf("dut%0d unexpected output", g), {19'd0, got}, 32'h1FFFF);
                        end else begin
                            e = q.pop_front();
                            chk($sformatf("dut%0d {err,acc,s,o,c,z}", g), {19'd0, got}, {19'd0, e});
                        end
                    end
                end
            end
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [1:0] s, input logic [7:0] d,
                         input logic [7:0] ea, input logic z, input logic c, input logic v,
                         input logic sf);
        @(posedge clk);
        #1;
        op_valid = 1'b1; op = o; sel = s; acc_in = d;
        q.push_back('{err: 1'b0, acc: ea, flg: {sf, v, c, z}});
    endtask

    task automatic issue_err(input logic [2:0] o, input logic [1:0] s,
                             input logic [7:0] hold_acc, input logic [3:0] hold_flg);
        @(posedge clk);
        #1;
        op_valid = 1'b1; op = o; sel = s; acc_in = 8'h5C;
        q.push_back('{err: 1'b1, acc: hold_acc, flg: hold_flg});
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        fork
            monitor();
        join_none

        repeat (2) @(posedge clk);
        #1;
        for (int g = 0; g < ND; g++) begin
            chk($sformatf("dut%0d reset acc_out", g), {24'd0, m_acc[g]}, 32'd0);
            chk($sformatf("dut%0d reset flags/valid/err", g), {26'd0, m_flg[g], m_ov[g], m_err[g]}, 32'd0);
        end
        rst = 1'b0;

        // Load/read, wrap arithmetic and boundary wraps on the plain configuration.
        act = 0;
        issue(OP_LD,  2'd0, 8'hAA, 8'hAA, 0, 0, 0, 0);
        issue(OP_NOP, 2'd0, 8'h00, 8'hAA, 0, 0, 0, 0);
        issue(OP_LD,  2'd0, 8'hF0, 8'hF0, 0, 0, 0, 0);
        issue(OP_ADD, 2'd0, 8'h20, 8'h10, 0, 1, 0, 0);
        issue(OP_SUB, 2'd0, 8'h20, 8'hF0, 0, 1, 0, 0);
        issue(OP_LD,  2'd1, 8'hFF, 8'hFF, 0, 0, 0, 0);
        issue(OP_INC, 2'd1, 8'h00, 8'h00, 1, 1, 0, 0);
        issue(OP_LD,  2'd2, 8'h80, 8'h80, 0, 0, 0, 0);
        issue(OP_DEC, 2'd2, 8'h00, 8'h7F, 0, 0, 1, 0);
        idle();

        // Bank isolation and reserved opcode.
        issue(OP_LD,  2'd0, 8'h11, 8'h11, 0, 0, 0, 0);
        issue(OP_LD,  2'd3, 8'h33, 8'h33, 0, 0, 0, 0);
        issue(OP_INC, 2'd0, 8'h00, 8'h12, 0, 0, 0, 0);
        issue(OP_INC, 2'd0, 8'h00, 8'h13, 0, 0, 0, 0);
        issue(OP_INC, 2'd0, 8'h00, 8'h14, 0, 0, 0, 0);
        issue(OP_NOP, 2'd3, 8'h00, 8'h33, 0, 0, 0, 0);
        issue(OP_NOP, 2'd0, 8'h00, 8'h14, 0, 0, 0, 0);
        issue_err(OP_RSV, 2'd0, 8'h14, 4'b0000);
        issue(OP_NOP, 2'd0, 8'h00, 8'h14, 0, 0, 0, 0);
        idle();

        // Unsigned saturation.
        act = 1;
        issue(OP_LD,  2'd0, 8'hF0, 8'hF0, 0, 0, 0, 0);
        issue(OP_ADD, 2'd0, 8'h20, 8'hFF, 0, 1, 0, 1);
        issue(OP_CLR, 2'd0, 8'h00, 8'h00, 1, 0, 0, 0);
        issue(OP_DEC, 2'd0, 8'h00, 8'h00, 1, 1, 0, 1);
        idle();

        // Signed saturation.
        act = 2;
        issue(OP_LD,  2'd0, 8'h70, 8'h70, 0, 0, 0, 0);
        issue(OP_ADD, 2'd0, 8'h20, 8'h7F, 0, 0, 1, 1);
        issue(OP_LD,  2'd0, 8'h90, 8'h90, 0, 0, 0, 0);
        issue(OP_SUB, 2'd0, 8'h20, 8'h80, 0, 0, 1, 1);
        idle();

        // Out-of-range select on the three-register bank.
        act = 3;
        issue(OP_LD,  2'd2, 8'h55, 8'h55, 0, 0, 0, 0);
        issue_err(OP_ADD, 2'd3, 8'h55, 4'b0000);
        issue(OP_NOP, 2'd2, 8'h00, 8'h55, 0, 0, 0, 0);
        idle();

        // Asynchronous reset between edges with ops in flight.
        act = 0;
        issue(OP_LD,  2'd0, 8'h5A, 8'h5A, 0, 0, 0, 0);
        issue(OP_ADD, 2'd0, 8'h01, 8'h5B, 0, 0, 0, 0);
        #2;
        rst = 1'b1;
        op_valid = 1'b0;
        q.delete();
        #1;
        chk("async rst acc_out", {24'd0, m_acc[0]}, 32'd0);
        chk("async rst flags/valid/err", {26'd0, m_flg[0], m_ov[0], m_err[0]}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        issue(OP_NOP, 2'd0, 8'h00, 8'h00, 1, 0, 0, 0);
        issue(OP_NOP, 2'd3, 8'h00, 8'h00, 1, 0, 0, 0);
        issue(OP_NOP, 2'd2, 8'h00, 8'h00, 1, 0, 0, 0);
        idle();

        repeat (3) @(posedge clk);
        chk("scoreboard drained", q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
